// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - memory request handshake between the sequencer and the memory port.
interface cpu_sequencer_if;
  logic mem_req;
  logic mem_we;
  logic addr_sel;
  logic mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output addr_sel,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  addr_sel,
    output mem_ack
  );
endinterface

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle CPU control sequencer with memory timeout fault.
// Register-load enables are decoded from state and mem_ack so loads land on the transition edge.
module cpu_sequencer #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int RETIRE_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  cpu_sequencer_if.master         mem,
  input  logic                    op_load,
  input  logic                    op_store,
  input  logic                    op_halt,
  output logic                    pc_en,
  output logic                    ir_en,
  output logic                    mar_en,
  output logic                    mdr_en,
  output logic                    rf_we,
  output logic [2:0]              state,
  output logic                    fault,
  output logic                    halted,
  output logic [RETIRE_WIDTH-1:0] retired
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                  r_state;
  state_t                  w_next;
  logic [7:0]              r_wait;
  logic                    r_is_store;
  logic                    r_fault;
  logic [RETIRE_WIDTH-1:0] r_retired;

  logic w_req;
  logic w_we;
  logic w_addr_sel;
  logic w_pc_en;
  logic w_ir_en;
  logic w_mar_en;
  logic w_mdr_en;
  logic w_rf_we;
  logic w_timeout;
  logic w_mem_phase;

  assign w_timeout   = (r_wait == WAIT_LAST);
  assign w_mem_phase = (r_state == S_FETCH) || (r_state == S_MEM);

  always_comb begin
    w_next     = r_state;
    w_req      = 1'b0;
    w_we       = 1'b0;
    w_addr_sel = 1'b0;
    w_pc_en    = 1'b0;
    w_ir_en    = 1'b0;
    w_mar_en   = 1'b0;
    w_mdr_en   = 1'b0;
    w_rf_we    = 1'b0;
    case (r_state)
      S_RESET: w_next = S_FETCH;
      S_FETCH: begin
        w_req = 1'b1;
        if (mem.mem_ack) begin
          w_ir_en = 1'b1;
          w_next  = S_DECODE;
        end else if (w_timeout) begin
          w_next = S_FAULT;
        end
      end
      S_DECODE: begin
        if (op_halt) begin
          w_next = S_HALT;
        end else if (op_load || op_store) begin
          w_mar_en = 1'b1;
          w_next   = S_MEM;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        w_rf_we = 1'b1;
        w_pc_en = 1'b1;
        w_next  = S_FETCH;
      end
      S_MEM: begin
        // Request, direction and address source stay fixed for the whole access.
        w_req      = 1'b1;
        w_addr_sel = 1'b1;
        w_we       = r_is_store;
        if (mem.mem_ack) begin
          if (r_is_store) begin
            w_pc_en = 1'b1;
            w_next  = S_FETCH;
          end else begin
            w_mdr_en = 1'b1;
            w_next   = S_WB;
          end
        end else if (w_timeout) begin
          w_next = S_FAULT;
        end
      end
      S_WB: begin
        w_rf_we = 1'b1;
        w_pc_en = 1'b1;
        w_next  = S_FETCH;
      end
      S_HALT:  w_next = S_HALT;
      S_FAULT: w_next = S_FAULT;
      default: w_next = S_FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_RESET;
      r_wait     <= 8'd0;
      r_is_store <= 1'b0;
      r_fault    <= 1'b0;
      r_retired  <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_wait <= 8'd0;
      end else if (w_mem_phase && !mem.mem_ack) begin
        r_wait <= r_wait + 8'd1;
      end
      if (w_mar_en) begin
        r_is_store <= op_store;
      end
      if (w_next == S_FAULT) begin
        r_fault <= 1'b1;
      end
      if (w_pc_en) begin
        r_retired <= r_retired + RETIRE_WIDTH'(1);
      end
    end
  end

  // Enables are masked by rst so a late ack during reset cannot load IR or MDR.
  assign pc_en  = w_pc_en  & ~rst;
  assign ir_en  = w_ir_en  & ~rst;
  assign mar_en = w_mar_en & ~rst;
  assign mdr_en = w_mdr_en & ~rst;
  assign rf_we  = w_rf_we  & ~rst;

  assign mem.mem_req  = w_req;
  assign mem.mem_we   = w_we;
  assign mem.addr_sel = w_addr_sel;

  assign state   = r_state;
  assign fault   = r_fault;
  assign halted  = (r_state == S_HALT);
  assign retired = r_retired;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - scoreboard bench for cpu_sequencer with short timeout and narrow retire counter.
module tb_cpu_sequencer;
  localparam logic [7:0] MR  = 8'h80;
  localparam logic [7:0] WE  = 8'h40;
  localparam logic [7:0] AS  = 8'h20;
  localparam logic [7:0] PC  = 8'h10;
  localparam logic [7:0] IR  = 8'h08;
  localparam logic [7:0] MAR = 8'h04;
  localparam logic [7:0] MDR = 8'h02;
  localparam logic [7:0] RF  = 8'h01;
  localparam logic [1:0] OP_ALU = 2'd0;
  localparam logic [1:0] OP_LD  = 2'd1;
  localparam logic [1:0] OP_ST  = 2'd2;
  localparam logic [1:0] OP_HLT = 2'd3;

  typedef struct packed {
    logic       r;
    logic       a;
    logic [1:0] op;
    logic [2:0] st;
    logic [7:0] c;
    logic       f;
    logic       h;
  } row_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       op_load, op_store, op_halt;
  logic       pc_en, ir_en, mar_en, mdr_en, rf_we;
  logic [2:0] state;
  logic       fault, halted;
  logic [3:0] retired;

  int checks = 0;
  int failures = 0;
  logic [3:0] ret = 4'd0;
  logic [16:0] sb[$];

  cpu_sequencer_if bus ();

  cpu_sequencer #(.TIMEOUT_CYCLES(4), .RETIRE_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .mem(bus.master),
    .op_load(op_load), .op_store(op_store), .op_halt(op_halt),
    .pc_en(pc_en), .ir_en(ir_en), .mar_en(mar_en), .mdr_en(mdr_en), .rf_we(rf_we),
    .state(state), .fault(fault), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  function automatic row_t mk(logic r, logic a, logic [1:0] op, logic [2:0] st,
                              logic [7:0] c, logic f, logic h);
    row_t x;
    x.r = r; x.a = a; x.op = op; x.st = st; x.c = c; x.f = f; x.h = h;
    return x;
  endfunction

  function automatic logic [16:0] observed();
    return {state, bus.mem_req, bus.mem_we, bus.addr_sel, pc_en, ir_en, mar_en, mdr_en, rf_we,
            fault, halted, retired};
  endfunction

  task automatic drive(input row_t x);
    rst = x.r;
    bus.mem_ack = x.a;
    op_load  = (x.op == OP_LD);
    op_store = (x.op == OP_ST);
    op_halt  = (x.op == OP_HLT);
    sb.push_back({x.st, x.c, x.f, x.h, ret});
    if (x.r) ret = 4'd0;
    else if (x.c & PC) ret = ret + 4'd1;
  endtask

  task automatic test_reset();
    row_t rows[$];
    logic [16:0] got, e;
    rows.push_back(mk(1, 1, OP_ALU, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, OP_ALU, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, OP_ALU, 1, MR, 0, 0));
    rows.push_back(mk(1, 1, OP_ALU, 1, MR, 0, 0));
    rows.push_back(mk(0, 1, OP_ALU, 0, 0, 0, 0));
    for (int i = 0; i < rows.size(); i++) begin
      @(negedge clk); drive(rows[i]); #2;
      got = observed(); e = sb.pop_front(); checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL reset row=%0d got=%h exp=%h", i, got, e);
      end
    end
  endtask

  task automatic test_alu(input int waits);
    row_t rows[$];
    logic [16:0] got, e;
    for (int w = 0; w < waits; w++) rows.push_back(mk(0, 0, OP_ALU, 1, MR, 0, 0));
    rows.push_back(mk(0, 1, OP_ALU, 1, MR | IR, 0, 0));
    rows.push_back(mk(0, 0, OP_ALU, 2, 0, 0, 0));
    rows.push_back(mk(0, 0, OP_ALU, 3, PC | RF, 0, 0));
    for (int i = 0; i < rows.size(); i++) begin
      @(negedge clk); drive(rows[i]); #2;
      got = observed(); e = sb.pop_front(); checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL alu waits=%0d row=%0d got=%h exp=%h", waits, i, got, e);
      end
    end
  endtask

  task automatic test_load();
    row_t rows[$];
    logic [16:0] got, e;
    rows.push_back(mk(0, 1, OP_LD, 1, MR | IR, 0, 0));
    rows.push_back(mk(0, 0, OP_LD, 2, MAR, 0, 0));
    rows.push_back(mk(0, 0, OP_LD, 4, MR | AS, 0, 0));
    rows.push_back(mk(0, 0, OP_LD, 4, MR | AS, 0, 0));
    rows.push_back(mk(0, 1, OP_LD, 4, MR | AS | MDR, 0, 0));
    rows.push_back(mk(0, 0, OP_LD, 5, PC | RF, 0, 0));
    for (int i = 0; i < rows.size(); i++) begin
      @(negedge clk); drive(rows[i]); #2;
      got = observed(); e = sb.pop_front(); checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL load row=%0d got=%h exp=%h", i, got, e);
      end
    end
  endtask

  task automatic test_store();
    row_t rows[$];
    logic [16:0] got, e;
    rows.push_back(mk(0, 1, OP_ST, 1, MR | IR, 0, 0));
    rows.push_back(mk(0, 1, OP_ST, 2, MAR, 0, 0));
    rows.push_back(mk(0, 0, OP_ST, 4, MR | WE | AS, 0, 0));
    rows.push_back(mk(0, 0, OP_ST, 4, MR | WE | AS, 0, 0));
    rows.push_back(mk(0, 1, OP_ST, 4, MR | WE | AS | PC, 0, 0));
    rows.push_back(mk(0, 0, OP_ALU, 1, MR, 0, 0));
    for (int i = 0; i < rows.size(); i++) begin
      @(negedge clk); drive(rows[i]); #2;
      got = observed(); e = sb.pop_front(); checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL store row=%0d got=%h exp=%h", i, got, e);
      end
    end
  endtask

  task automatic test_wrap();
    row_t rows[$];
    logic [16:0] got, e;
    int n;
    n = 16 - int'(ret);
    for (int k = 0; k < n; k++) begin
      if (k != 0) begin
        for (int w = 0; w < int'($urandom_range(0, 2)); w++)
          rows.push_back(mk(0, 0, OP_ALU, 1, MR, 0, 0));
      end
      rows.push_back(mk(0, 1, OP_ALU, 1, MR | IR, 0, 0));
      rows.push_back(mk(0, 0, OP_ALU, 2, 0, 0, 0));
      rows.push_back(mk(0, 0, OP_ALU, 3, PC | RF, 0, 0));
    end
    rows.push_back(mk(0, 0, OP_ALU, 1, MR, 0, 0));
    for (int i = 0; i < rows.size(); i++) begin
      @(negedge clk); drive(rows[i]); #2;
      got = observed(); e = sb.pop_front(); checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL wrap row=%0d got=%h exp=%h", i, got, e);
      end
    end
    checks++;
    if (retired !== 4'd0) begin
      failures++;
      $display("FAIL wrap_zero got=%0d exp=0", retired);
    end
  endtask

  task automatic test_halt();
    row_t rows[$];
    logic [16:0] got, e;
    rows.push_back(mk(0, 1, OP_HLT, 1, MR | IR, 0, 0));
    rows.push_back(mk(0, 0, OP_HLT, 2, 0, 0, 0));
    rows.push_back(mk(0, 1, OP_HLT, 6, 0, 0, 1));
    rows.push_back(mk(0, 0, OP_LD, 6, 0, 0, 1));
    rows.push_back(mk(1, 0, OP_ALU, 6, 0, 0, 1));
    rows.push_back(mk(0, 0, OP_ALU, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, OP_ALU, 1, MR, 0, 0));
    for (int i = 0; i < rows.size(); i++) begin
      @(negedge clk); drive(rows[i]); #2;
      got = observed(); e = sb.pop_front(); checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL halt row=%0d got=%h exp=%h", i, got, e);
      end
    end
  endtask

  task automatic test_timeout();
    row_t rows[$];
    logic [16:0] got, e;
    rows.push_back(mk(1, 0, OP_ALU, 1, MR, 0, 0));
    rows.push_back(mk(0, 0, OP_ALU, 0, 0, 0, 0));
    for (int w = 0; w < 4; w++) rows.push_back(mk(0, 0, OP_ALU, 1, MR, 0, 0));
    rows.push_back(mk(0, 1, OP_ALU, 7, 0, 1, 0));
    rows.push_back(mk(0, 1, OP_LD, 7, 0, 1, 0));
    rows.push_back(mk(0, 0, OP_HLT, 7, 0, 1, 0));
    for (int i = 0; i < rows.size(); i++) begin
      @(negedge clk); drive(rows[i]); #2;
      got = observed(); e = sb.pop_front(); checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL timeout row=%0d got=%h exp=%h", i, got, e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.mem_ack = 1'b0;
    op_load = 1'b0; op_store = 1'b0; op_halt = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_alu(0);
    test_alu(3);
    test_load();
    test_store();
    test_wrap();
    test_halt();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL take parameter TIMEOUT_CYCLES, default 15: count of consecutive un-acknowledged memory-request cycles that raises a fault; legal range 1..255.
REQ-002 SHALL take parameter RETIRE_WIDTH, default 16: width of the retired-instruction counter.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port mem_ack, input, 1: memory has completed the current request this cycle.
REQ-006 SHALL have ports op_load, op_store and op_halt, each input, 1: decode of the current instruction register contents; at most one is set; none set means ALU op.
REQ-007 SHALL have port mem_req, output, 1: memory request.
REQ-008 SHALL have port mem_we, output, 1: write strobe, qualified by mem_req.
REQ-009 SHALL have port addr_sel, output, 1: memory address source; 0 = PC, 1 = MAR.
REQ-010 SHALL have ports pc_en, ir_en, mar_en, mdr_en and rf_we, each output, 1: load enables for the PC, instruction, MAR and MDR registers and the register file.
REQ-011 SHALL have port state, output, 3: current state encoding.
REQ-012 SHALL have port fault, output, 1: sticky timeout fault.
REQ-013 SHALL have port halted, output, 1: high while in HALT.
REQ-014 SHALL have port retired, output, RETIRE_WIDTH: count of retired instructions.

Function
REQ-015 SHALL implement states RESET=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, FAULT=7, output on state.
REQ-016 SHALL move from RESET to FETCH unconditionally after one cycle.
REQ-017 In FETCH: mem_req=1, mem_we=0, addr_sel=0; if mem_ack=1, ir_en=1 in that same cycle and next state is DECODE; otherwise remain in FETCH.
REQ-018 In DECODE (exactly 1 cycle), on op_halt: go to HALT.
REQ-019 In DECODE, on op_load or op_store: mar_en=1, latch op_store into an internal is_store flag, and go to MEM.
REQ-020 In DECODE, with no op flag set: go to EXEC.
REQ-021 In EXEC: rf_we=1, pc_en=1, go to FETCH.
REQ-022 In MEM: mem_req=1, addr_sel=1, mem_we=is_store, all held stable until ack.
REQ-023 In MEM with mem_ack=1 and a load: mdr_en=1, go to WB.
REQ-024 In MEM with mem_ack=1 and a store: pc_en=1, go to FETCH.
REQ-025 In WB: rf_we=1, pc_en=1, go to FETCH.
REQ-026 HALT and FAULT SHALL be absorbing until rst; all enables and mem_req SHALL be 0 in both.
REQ-027 Enables SHALL be decoded from state plus mem_ack, so the controlled register loads on the same edge as the state transition; every enable not listed for a state SHALL be 0.
REQ-028 SHALL keep a wait counter (8 bits) that clears on entry to FETCH or MEM and increments each FETCH/MEM cycle with mem_ack=0.
REQ-029 When mem_ack=0 and the wait counter equals TIMEOUT_CYCLES-1, next state SHALL be FAULT and fault SHALL set.
REQ-030 mem_ack=1 SHALL take priority over timeout in the same cycle.
REQ-031 mem_ack SHALL be ignored outside FETCH and MEM.
REQ-032 retired SHALL increment by 1 on every cycle with pc_en=1, wrapping from all-ones to 0.
REQ-033 halted SHALL equal (state==HALT).

Reset
REQ-034 When rst=1 at a rising edge: state=RESET, fault=0, retired=0, wait counter=0, is_store=0, regardless of current state, including mid-request.
REQ-035 During the RESET state all enables, mem_req and mem_we SHALL be 0; rst asserted while mem_ack=1 SHALL NOT produce ir_en or mdr_en.

Verification
REQ-036 Bench SHALL cover an ALU op with ack on the 1st FETCH cycle: states 1,2,3,1 and pulses ir_en, rf_we+pc_en; retired 0->1.
REQ-037 Bench SHALL cover a load with ack after 2 wait cycles in MEM: mar_en in DECODE, addr_sel=1 for 3 cycles, mdr_en with ack, WB rf_we+pc_en; retired +1.
REQ-038 Bench SHALL cover a store: mem_we=1 for every MEM cycle, pc_en on the ack cycle, no rf_we, next state FETCH.
REQ-039 Bench SHALL cover TIMEOUT_CYCLES=4 with mem_ack held 0 in FETCH: FAULT entered after exactly 4 FETCH cycles; fault=1; all enables 0 thereafter.
REQ-040 Bench SHALL cover retired preset near wrap (RETIRE_WIDTH=4, 15 ALU ops followed by 1 more): retired reads 15 then 0.
REQ-041 Bench SHALL cover op_halt in DECODE: halted=1, then rst=1 for 1 cycle: state=RESET, retired=0, fault=0, then FETCH.
